// File: rtl/traffic_phase_sched_pkg.sv
// traffic_pkg: shared state encoding, signal-head constants and decode helpers
// for the two-road phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_G1   = 3'd1,
    ST_Y1   = 3'd2,
    ST_AR1  = 3'd3,
    ST_G2   = 3'd4,
    ST_Y2   = 3'd5,
    ST_AR2  = 3'd6
  } state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // Road 1 head for a given state; red everywhere road 1 does not own the junction.
  function automatic logic [2:0] head1(state_t s);
    case (s)
      ST_G1:   head1 = LIGHT_GRN;
      ST_Y1:   head1 = LIGHT_YEL;
      default: head1 = LIGHT_RED;
    endcase
  endfunction

  // Road 2 head for a given state.
  function automatic logic [2:0] head2(state_t s);
    case (s)
      ST_G2:   head2 = LIGHT_GRN;
      ST_Y2:   head2 = LIGHT_YEL;
      default: head2 = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_sched_if.sv
// traffic_phase_sched_if: control inputs and signal-head/status outputs of the
// phase scheduler. The master side drives start/requests; the slave is the block.
interface traffic_phase_sched_if #(
  parameter int CW = 6
) ();
  logic          start;
  logic          req1;
  logic          req2;
  logic [2:0]    signal1;
  logic [2:0]    signal2;
  logic [CW-1:0] remain;
  logic          wait1;
  logic          wait2;

  modport master (
    output start, req1, req2,
    input  signal1, signal2, remain, wait1, wait2
  );

  modport slave (
    input  start, req1, req2,
    output signal1, signal2, remain, wait1, wait2
  );
endinterface

// File: rtl/traffic_phase_sched_timer.sv
// phase_timer: CW-bit down-counter. A load overrides counting; otherwise the
// count decrements and parks at zero. o_zero flags the final cycle of a phase.
module phase_timer #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_value,
  output logic [CW-1:0] o_count,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  // Load on phase entry, otherwise count down towards zero and hold there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: self-timed two-road phase scheduler.
// Build option: define TRAFFIC_DEMAND_EN to hold each green at its end until
// the crossing road has a pending request (wait bits latched from req1/req2).
// Without it the block runs a fixed-time cycle and the wait outputs read 0.
//
//  state  | meaning
//  IDLE   | waiting for start, all heads red
//  G1     | road 1 green
//  Y1     | road 1 yellow
//  AR1    | all-red clearance after road 1
//  G2     | road 2 green
//  Y2     | road 2 yellow
//  AR2    | all-red clearance after road 2
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = 25,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int CW       = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_phase_sched_if.slave  bus
);

  localparam logic [CW-1:0] GREEN_LD  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] YELLOW_LD = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LD = CW'(ALLRED_T - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic [CW-1:0] w_count;
  logic          w_zero;
  logic          w_g1_release;
  logic          w_g2_release;
  logic [2:0]    r_sig1;
  logic [2:0]    r_sig2;

  phase_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_count (w_count),
    .o_zero  (w_zero)
  );

`ifdef TRAFFIC_DEMAND_EN
  logic r_wait1;
  logic r_wait2;
  logic w_enter_g1;
  logic w_enter_g2;

  // A green may only end once the crossing road is actually waiting.
  assign w_g1_release = r_wait2;
  assign w_g2_release = r_wait1;
  assign w_enter_g1   = w_load && (w_state_nxt == ST_G1);
  assign w_enter_g2   = w_load && (w_state_nxt == ST_G2);

  // Request latches: cleared as the road gets its green, but a request on the
  // same edge is ORed in afterwards so it is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait1 <= 1'b0;
      r_wait2 <= 1'b0;
    end else begin
      r_wait1 <= (r_wait1 & ~w_enter_g1) | bus.req1;
      r_wait2 <= (r_wait2 & ~w_enter_g2) | bus.req2;
    end
  end

  assign bus.wait1 = r_wait1;
  assign bus.wait2 = r_wait2;
`else
  assign w_g1_release = 1'b1;
  assign w_g2_release = 1'b1;
  assign bus.wait1    = 1'b0;
  assign bus.wait2    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: start leaves IDLE, otherwise a phase ends when the timer is zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start)              w_state_nxt = ST_G1;
      ST_G1:   if (w_zero && w_g1_release) w_state_nxt = ST_Y1;
      ST_Y1:   if (w_zero)                 w_state_nxt = ST_AR1;
      ST_AR1:  if (w_zero)                 w_state_nxt = ST_G2;
      ST_G2:   if (w_zero && w_g2_release) w_state_nxt = ST_Y2;
      ST_Y2:   if (w_zero)                 w_state_nxt = ST_AR2;
      ST_AR2:  if (w_zero)                 w_state_nxt = ST_G1;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  // Every state change reloads the timer with the new phase length minus one.
  always_comb begin
    w_load     = (w_state_nxt != r_state);
    w_load_val = '0;
    case (w_state_nxt)
      ST_G1, ST_G2:   w_load_val = GREEN_LD;
      ST_Y1, ST_Y2:   w_load_val = YELLOW_LD;
      ST_AR1, ST_AR2: w_load_val = ALLRED_LD;
      default:        w_load_val = '0;
    endcase
  end

  // Registered heads, decoded from the state being entered so they align with r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sig1 <= LIGHT_RED;
      r_sig2 <= LIGHT_RED;
    end else begin
      r_sig1 <= head1(w_state_nxt);
      r_sig2 <= head2(w_state_nxt);
    end
  end

  assign bus.signal1 = r_sig1;
  assign bus.signal2 = r_sig2;
  assign bus.remain  = w_count;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Bench for traffic_phase_sched: reset/idle, fixed-cycle vector table,
// randomized run against a phase-list reference model, mid-phase reset and
// (demand builds) request hold/collision sequences.
module tb_traffic_phase_sched;

  localparam int GT = 5;
  localparam int YT = 2;
  localparam int AT = 1;
  localparam int CWB = 4;
  localparam bit [2:0] RED = 3'b100;
  localparam bit [2:0] YEL = 3'b010;
  localparam bit [2:0] GRN = 3'b001;

`ifdef TRAFFIC_DEMAND_EN
  localparam bit DEMAND = 1'b1;
`else
  localparam bit DEMAND = 1'b0;
`endif

  logic clk;
  logic rst;

  traffic_phase_sched_if #(.CW(CWB)) bus ();

  traffic_phase_sched #(
    .GREEN_T (GT),
    .YELLOW_T(YT),
    .ALLRED_T(AT),
    .CW      (CWB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: the cycle is an ordered list of six phases with lengths.
  int       dur [6];
  bit [2:0] h1  [6];
  bit [2:0] h2  [6];
  bit       m_idle;
  int       m_ph;
  int       m_left;
  bit       m_w1;
  bit       m_w2;

  task automatic model_reset();
    m_idle = 1'b1;
    m_ph   = 0;
    m_left = 0;
    m_w1   = 1'b0;
    m_w2   = 1'b0;
  endtask

  // Predict the state after one rising edge given the inputs held before it.
  task automatic model_step(input bit st, input bit r1, input bit r2);
    int nph;
    bit moved;
    bit hold;
    nph   = m_ph;
    moved = 1'b0;
    hold  = 1'b0;
    if (m_idle) begin
      if (st) begin
        m_idle = 1'b0;
        nph    = 0;
        moved  = 1'b1;
      end
    end else if (m_left == 0) begin
      if (DEMAND)
        hold = (m_ph == 0 && !m_w2) || (m_ph == 3 && !m_w1);
      if (!hold) begin
        nph   = (m_ph + 1) % 6;
        moved = 1'b1;
      end
    end else begin
      m_left = m_left - 1;
    end
    if (moved) m_left = dur[nph] - 1;
    if (DEMAND) begin
      if (moved && nph == 0) m_w1 = 1'b0;
      if (moved && nph == 3) m_w2 = 1'b0;
      m_w1 = m_w1 | r1;
      m_w2 = m_w2 | r2;
    end
    m_ph = nph;
  endtask

  typedef struct {
    bit       start;
    bit [2:0] s1;
    bit [2:0] s2;
    int       rem;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int n;
    bit st, r1, r2;

    dur[0] = GT; dur[1] = YT; dur[2] = AT; dur[3] = GT; dur[4] = YT; dur[5] = AT;
    h1[0] = GRN; h1[1] = YEL; h1[2] = RED; h1[3] = RED; h1[4] = RED; h1[5] = RED;
    h2[0] = RED; h2[1] = RED; h2[2] = RED; h2[3] = GRN; h2[4] = YEL; h2[5] = RED;

    // Fixed cycle after a start pulse; start=1 mid-cycle must be ignored.
    vecs[0]  = '{1'b1, GRN, RED, 4};
    vecs[1]  = '{1'b0, GRN, RED, 3};
    vecs[2]  = '{1'b0, GRN, RED, 2};
    vecs[3]  = '{1'b1, GRN, RED, 1};
    vecs[4]  = '{1'b0, GRN, RED, 0};
    vecs[5]  = '{1'b0, YEL, RED, 1};
    vecs[6]  = '{1'b1, YEL, RED, 0};
    vecs[7]  = '{1'b0, RED, RED, 0};
    vecs[8]  = '{1'b0, RED, GRN, 4};
    vecs[9]  = '{1'b0, RED, GRN, 3};
    vecs[10] = '{1'b0, RED, GRN, 2};
    vecs[11] = '{1'b0, RED, GRN, 1};
    vecs[12] = '{1'b0, RED, GRN, 0};
    vecs[13] = '{1'b0, RED, YEL, 1};
    vecs[14] = '{1'b0, RED, YEL, 0};
    vecs[15] = '{1'b0, RED, RED, 0};
    vecs[16] = '{1'b0, GRN, RED, 4};

    bus.start = 1'b0;
    bus.req1  = 1'b0;
    bus.req2  = 1'b0;
    rst       = 1'b1;

    // Reset and idle.
    #2 rst = 1'b0;
    #1;
    check("rst_sig1", bus.signal1, RED);
    check("rst_sig2", bus.signal2, RED);
    check("rst_remain", bus.remain, 0);
    check("rst_wait1", bus.wait1, 0);
    check("rst_wait2", bus.wait2, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_sig1", bus.signal1, RED);
      check("idle_sig2", bus.signal2, RED);
      check("idle_remain", bus.remain, 0);
    end

`ifndef TRAFFIC_DEMAND_EN
    // Fixed cycle vector table; entry 16 closes the 16-cycle period.
    for (int i = 0; i < 17; i++) begin
      bus.start = vecs[i].start;
      tick();
      check($sformatf("vec%0d_sig1", i), bus.signal1, vecs[i].s1);
      check($sformatf("vec%0d_sig2", i), bus.signal2, vecs[i].s2);
      check($sformatf("vec%0d_remain", i), bus.remain, vecs[i].rem);
    end
    bus.start = 1'b0;
`else
    // Demand hold: no requests keeps G1 with remain 0.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    check("hold_sig1", bus.signal1, GRN);
    check("hold_remain", bus.remain, 0);
    bus.req2 = 1'b1;
    tick();
    bus.req2 = 1'b0;
    check("req2_wait2", bus.wait2, 1);
    check("req2_still_g1", bus.signal1, GRN);
    tick();
    check("enter_y1", bus.signal1, YEL);
    tick();
    tick();
    check("ar1_sig1", bus.signal1, RED);
    check("ar1_sig2", bus.signal2, RED);
    tick();
    check("enter_g2", bus.signal2, GRN);
    check("g2_wait2_clear", bus.wait2, 0);

    // Collision: req1 on the edge that enters G1 keeps wait1 set.
    bus.req1 = 1'b1;
    tick();
    bus.req1 = 1'b0;
    check("req1_wait1", bus.wait1, 1);
    n = 0;
    while (bus.signal2 != YEL && n < 20) begin tick(); n++; end
    check("reach_y2", bus.signal2, YEL);
    n = 0;
    while (bus.signal2 != RED && n < 20) begin tick(); n++; end
    check("reach_ar2", bus.signal2, RED);
    bus.req1 = 1'b1;
    tick();
    bus.req1 = 1'b0;
    check("coll_g1", bus.signal1, GRN);
    check("coll_wait1", bus.wait1, 1);
`endif

    // Randomized run against the reference model.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 150; i++) begin
      st = ($urandom_range(0, 9) == 0);
      r1 = ($urandom_range(0, 7) == 0);
      r2 = ($urandom_range(0, 7) == 0);
      bus.start = st;
      bus.req1  = r1;
      bus.req2  = r2;
      model_step(st, r1, r2);
      tick();
      check("rnd_sig1", bus.signal1, m_idle ? RED : h1[m_ph]);
      check("rnd_sig2", bus.signal2, m_idle ? RED : h2[m_ph]);
      check("rnd_remain", bus.remain, m_left);
      check("rnd_wait1", bus.wait1, m_w1);
      check("rnd_wait2", bus.wait2, m_w2);
      check("rnd_exclusive", (bus.signal1 != RED) && (bus.signal2 != RED), 0);
    end
    bus.start = 1'b0;
    bus.req1  = 1'b0;
    bus.req2  = 1'b0;

    // Reset asserted during Y2 clears everything without a clock edge.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.req1  = 1'b1;
    bus.req2  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.signal2 != YEL && n < 40) begin tick(); n++; end
    check("mid_reach_y2", bus.signal2, YEL);
    #1 rst = 1'b0;
    #1;
    check("mid_sig1", bus.signal1, RED);
    check("mid_sig2", bus.signal2, RED);
    check("mid_remain", bus.remain, 0);
    check("mid_wait1", bus.wait1, 0);
    check("mid_wait2", bus.wait2, 0);
    bus.req1 = 1'b0;
    bus.req2 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_idle", bus.signal1, RED);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
